// File: rtl/spike_neo_detector.sv
// Nonlinear energy operator spike detector with threshold compare and refractory lockout.
// Optional sample timestamping is enabled by defining SPIKE_NEO_TS_EN.
module spike_neo_detector #(
  parameter int BITSIZE    = 16,
  parameter int REFRAC_SMP = 32,
  parameter int TS_WIDTH   = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   EN,
  input  logic                   DATA_VALID,
  input  logic [BITSIZE-1:0]     DATA_IN,
  input  logic [2*BITSIZE-1:0]   THRESHOLD,
  output logic [2*BITSIZE-1:0]   NEO_OUT,
  output logic                   NEO_VALID,
  output logic                   SPIKE_DET,
  output logic [TS_WIDTH-1:0]    SPIKE_TS
);

  localparam int PW = 2 * BITSIZE;
  localparam int DW = PW + 1;
  localparam int RW = (REFRAC_SMP < 1) ? 1 : $clog2(REFRAC_SMP + 1);
  localparam logic [RW-1:0] REFRAC_LD = RW'(REFRAC_SMP);

  // Offset binary to two's complement: flip the MSB.
  function automatic logic signed [BITSIZE-1:0] to_signed(input logic [BITSIZE-1:0] v);
    return {~v[BITSIZE-1], v[BITSIZE-2:0]};
  endfunction

  function automatic logic [PW-1:0] clamp_neg(input logic signed [DW-1:0] d);
    return d[DW-1] ? '0 : d[PW-1:0];
  endfunction

  logic                      dv_q;
  logic                      accept;
  logic [1:0]                fill_cnt;
  logic signed [BITSIZE-1:0] x0_p0, x1_p0, x2_p0;
  logic                      vld_p0, vld_p1;
  logic signed [PW-1:0]      x0_w, x1_w, x2_w;
  logic signed [PW-1:0]      sq_p1, cross_p1;
  logic signed [DW-1:0]      diff_p1;
  logic [PW-1:0]             neo_next;
  logic                      spike_hit;
  logic [RW-1:0]             refrac_cnt;

  assign accept = EN & DATA_VALID & ~dv_q;

  always_comb begin
    x0_w      = PW'(x0_p0);
    x1_w      = PW'(x1_p0);
    x2_w      = PW'(x2_p0);
    diff_p1   = DW'(sq_p1) - DW'(cross_p1);
    neo_next  = clamp_neg(diff_p1);
    spike_hit = (neo_next > THRESHOLD) && (refrac_cnt == '0);
  end

  // Stage 0: edge-detected accept shifts the sample window
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dv_q       <= 1'b0;
      fill_cnt   <= 2'd0;
      x0_p0      <= '0;
      x1_p0      <= '0;
      x2_p0      <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      NEO_OUT    <= '0;
      NEO_VALID  <= 1'b0;
      SPIKE_DET  <= 1'b0;
      refrac_cnt <= '0;
    end else if (!EN) begin
      dv_q       <= 1'b0;
      fill_cnt   <= 2'd0;
      x0_p0      <= '0;
      x1_p0      <= '0;
      x2_p0      <= '0;
      vld_p0     <= 1'b0;
      vld_p1     <= 1'b0;
      NEO_OUT    <= '0;
      NEO_VALID  <= 1'b0;
      SPIKE_DET  <= 1'b0;
      refrac_cnt <= '0;
    end else begin
      dv_q   <= DATA_VALID;
      vld_p0 <= accept && (fill_cnt == 2'd2);
      if (accept) begin
        x0_p0 <= to_signed(DATA_IN);
        x1_p0 <= x0_p0;
        x2_p0 <= x1_p0;
        if (fill_cnt != 2'd2) fill_cnt <= fill_cnt + 2'd1;
      end
      vld_p1 <= vld_p0;
      // Stage 2: clamp, threshold and refractory update
      NEO_VALID <= vld_p1;
      SPIKE_DET <= vld_p1 && spike_hit;
      if (vld_p1) begin
        NEO_OUT <= neo_next;
        if (spike_hit) refrac_cnt <= REFRAC_LD;
        else if (refrac_cnt != '0) refrac_cnt <= refrac_cnt - RW'(1);
      end
    end
  end

  // Stage 1: products (data only, qualified by vld_p1 downstream)
  always_ff @(posedge CLK) begin
    sq_p1    <= x1_w * x1_w;
    cross_p1 <= x0_w * x2_w;
  end

`ifdef SPIKE_NEO_TS_EN
  logic [TS_WIDTH-1:0] ts_cnt, cidx_p0, cidx_p1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ts_cnt   <= '0;
      cidx_p0  <= '0;
      cidx_p1  <= '0;
      SPIKE_TS <= '0;
    end else if (!EN) begin
      ts_cnt   <= '0;
      cidx_p0  <= '0;
      cidx_p1  <= '0;
      SPIKE_TS <= '0;
    end else begin
      // The new centre sample is the one accepted just before this one.
      if (accept) begin
        ts_cnt  <= ts_cnt + TS_WIDTH'(1);
        cidx_p0 <= ts_cnt - TS_WIDTH'(1);
      end
      cidx_p1 <= cidx_p0;
      if (vld_p1 && spike_hit) SPIKE_TS <= cidx_p1;
    end
  end
`else
  assign SPIKE_TS = '0;
`endif

endmodule
